// File: rtl/gray_pkg.sv
// Shared definitions for the Gray stream decoder: FSM encoding and Gray helpers.
// Purely combinational helpers; no latency.
// No flow control here; callers size operands to GMAX bits.
package gray_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    // Widest Gray word the helpers handle; narrower words are zero-extended
    localparam int GMAX = 32;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    // Zero-extension leaves the low bits of the result unchanged.
    function automatic logic [GMAX-1:0] g2b(input logic [GMAX-1:0] g);
        logic [GMAX-1:0] b;
        b[GMAX-1] = g[GMAX-1];
        for (int i = GMAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Number of set bits; 6 bits covers counts up to GMAX = 32
    function automatic logic [5:0] popcount(input logic [GMAX-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < GMAX; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Gray to binary converter of width W.
// Latency: combinational, zero cycles.
// No backpressure; output follows input.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    // Widen to the helper width, decode, keep the low W bits
    assign bin_o = W'(g2b(GMAX'(gray_i)));

endmodule

// File: rtl/gray_stream_decoder.sv
// Decodes a sampled Gray count stream to binary, checks single-bit steps, tracks lock.
// Latency: one cycle from the sampling edge to every registered output.
// No backpressure: a valid sample is accepted on every edge; valid_in low holds all state.
module gray_stream_decoder
    import gray_pkg::*;
#(
    parameter int W          = 2,
    parameter int RESYNC_LEN = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [W-1:0]         gray_in,
    output logic [W-1:0]         bin_out,
    output logic                 dir,
    output logic                 step_pulse,
    output logic                 step_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int RS_W = $clog2(RESYNC_LEN + 1);

    logic [1:0]           state_q,   state_d;
    logic [W-1:0]         prev_q,    prev_d;
    logic [W-1:0]         bin_q,     bin_d;
    logic                 dir_q,     dir_d;
    logic                 step_q,    step_d;
    logic                 err_q,     err_d;
    logic                 locked_q,  locked_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [RS_W-1:0]      rs_cnt_q,  rs_cnt_d;

    logic [W-1:0]         bin_in;
    logic [W-1:0]         bin_prev;
    logic [5:0]           pc;
    logic                 is_legal;
    logic                 is_illegal;
    logic                 is_up;
    logic [RS_W-1:0]      rs_inc;
    logic [ERR_CNT_W-1:0] err_cnt_sat;

    gray_to_bin #(.W(W)) u_g2b_in   (.gray_i(gray_in), .bin_o(bin_in));
    gray_to_bin #(.W(W)) u_g2b_prev (.gray_i(prev_q),  .bin_o(bin_prev));

    // Classify the incoming sample against the last anchored value
    always_comb begin
        pc          = popcount(GMAX'(gray_in ^ prev_q));
        is_legal    = (pc == 6'd1);
        is_illegal  = (pc >= 6'd2);
        is_up       = (bin_in == bin_prev + W'(1));
        rs_inc      = rs_cnt_q + RS_W'(1);
        err_cnt_sat = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
    end

    // Next-state logic; pulses default low, everything else holds
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        bin_d     = bin_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        rs_cnt_d  = rs_cnt_q;
        if (valid_in) begin
            case (state_q)
                IDLE: begin
                    // First sample only anchors; it is never a step
                    prev_d  = gray_in;
                    bin_d   = bin_in;
                    state_d = TRACK;
                end
                TRACK: begin
                    if (is_legal) begin
                        prev_d = gray_in;
                        bin_d  = bin_in;
                        dir_d  = is_up;
                        step_d = 1'b1;
                    end else if (is_illegal) begin
                        prev_d    = gray_in;
                        bin_d     = bin_in;
                        err_d     = 1'b1;
                        err_cnt_d = err_cnt_sat;
                        rs_cnt_d  = '0;
                        state_d   = FAULT;
                    end
                end
                FAULT: begin
                    // Every sample re-anchors while we hunt for a clean run
                    prev_d = gray_in;
                    bin_d  = bin_in;
                    if (is_legal) begin
                        dir_d  = is_up;
                        step_d = 1'b1;
                        if (rs_inc == RS_W'(RESYNC_LEN)) begin
                            rs_cnt_d = '0;
                            state_d  = TRACK;
                        end else begin
                            rs_cnt_d = rs_inc;
                        end
                    end else if (is_illegal) begin
                        err_d     = 1'b1;
                        err_cnt_d = err_cnt_sat;
                        rs_cnt_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        locked_d = (state_d == TRACK);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            bin_q     <= '0;
            dir_q     <= 1'b0;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
            err_cnt_q <= '0;
            rs_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            bin_q     <= bin_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
            err_cnt_q <= err_cnt_d;
            rs_cnt_q  <= rs_cnt_d;
        end
    end

    assign bin_out    = bin_q;
    assign dir        = dir_q;
    assign step_pulse = step_q;
    assign step_err   = err_q;
    assign locked     = locked_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Directed bench for gray_stream_decoder: main instance plus a 2-bit error counter instance.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns after the edge.
// Expected values are hand-derived from the Gray sequences applied.
module tb_gray_stream_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [1:0] gray_in = 2'b00;
    logic [1:0] bin_out;
    logic       dir, step_pulse, step_err, locked;
    logic [7:0] err_cnt;

    logic       valid2 = 1'b0;
    logic [1:0] gray2 = 2'b00;
    logic [1:0] bin2;
    logic       dir2, sp2, se2, lk2;
    logic [1:0] ec2;

    int vectors = 0;
    int miscompares = 0;

    gray_stream_decoder #(.W(2), .RESYNC_LEN(2), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .gray_in(gray_in),
        .bin_out(bin_out), .dir(dir), .step_pulse(step_pulse),
        .step_err(step_err), .locked(locked), .err_cnt(err_cnt)
    );

    gray_stream_decoder #(.W(2), .RESYNC_LEN(2), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .valid_in(valid2), .gray_in(gray2),
        .bin_out(bin2), .dir(dir2), .step_pulse(sp2),
        .step_err(se2), .locked(lk2), .err_cnt(ec2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check every output of the main instance
    task automatic chk_all(input string tag, input logic [1:0] b, input logic d,
                           input logic sp, input logic se, input logic lk, input logic [7:0] ec);
        chk({tag, ".bin"},    32'(bin_out),    32'(b));
        chk({tag, ".dir"},    32'(dir),        32'(d));
        chk({tag, ".step"},   32'(step_pulse), 32'(sp));
        chk({tag, ".err"},    32'(step_err),   32'(se));
        chk({tag, ".locked"}, 32'(locked),     32'(lk));
        chk({tag, ".errcnt"}, 32'(err_cnt),    32'(ec));
    endtask

    // Drive one cycle on the main instance (saturation instance idle)
    task automatic apply(input logic v, input logic [1:0] g);
        valid_in = v;
        gray_in  = g;
        valid2   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on the saturation instance (main instance idle)
    task automatic apply2(input logic [1:0] g);
        valid_in = 1'b0;
        valid2   = 1'b1;
        gray2    = g;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Asynchronous reset with arbitrary inputs, checked before any clock edge
        #1;
        valid_in = 1'b1;
        gray_in  = 2'b11;
        rst      = 1'b0;
        #2;
        chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("reset.sat_errcnt", 32'(ec2), 32'd0);
        chk("reset.sat_locked", 32'(lk2), 32'd0);
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // IDLE anchor
        apply(1'b1, 2'b00); chk_all("anchor", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Up sweep with wrap 3 -> 0
        apply(1'b1, 2'b01); chk_all("up1", 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
        apply(1'b1, 2'b11); chk_all("up2", 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
        apply(1'b1, 2'b10); chk_all("up3", 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
        apply(1'b1, 2'b00); chk_all("upwrap", 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);

        // Down with wrap 0 -> 3, a repeated sample, then idle cycles
        apply(1'b1, 2'b10); chk_all("dnwrap", 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        apply(1'b1, 2'b10); chk_all("same",   2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        apply(1'b1, 2'b11); chk_all("dn2",    2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        apply(1'b0, 2'b00); chk_all("hold1",  2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        apply(1'b0, 2'b01); chk_all("hold2",  2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        apply(1'b0, 2'b10); chk_all("hold3",  2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Walk back to 00 while locked
        apply(1'b1, 2'b01); chk_all("dn1", 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        apply(1'b1, 2'b00); chk_all("dn0", 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);

        // Illegal jump 00 -> 11, then two legal steps relock
        apply(1'b1, 2'b11); chk_all("ill1",  2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
        apply(1'b1, 2'b01); chk_all("rs1",   2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        apply(1'b1, 2'b00); chk_all("relock",2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);

        // Illegal again; an illegal step mid-resync restarts the count
        apply(1'b1, 2'b11); chk_all("ill2",   2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
        apply(1'b1, 2'b10); chk_all("rsup",   2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
        apply(1'b1, 2'b01); chk_all("ill3",   2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
        apply(1'b1, 2'b00); chk_all("rsrst",  2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        apply(1'b1, 2'b00); chk_all("fsame",  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        apply(1'b1, 2'b01); chk_all("relock2",2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3);

        // Enter FAULT for the mid-operation reset check
        apply(1'b1, 2'b10); chk_all("ill4", 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4);

        // Saturation on the 2-bit counter instance
        apply2(2'b00); chk("sat.anchor", 32'(ec2), 32'd0); chk("sat.anchor_lk", 32'(lk2), 32'd1);
        apply2(2'b11); chk("sat1", 32'(ec2), 32'd1); chk("sat1.err", 32'(se2), 32'd1);
        apply2(2'b00); chk("sat2", 32'(ec2), 32'd2); chk("sat2.err", 32'(se2), 32'd1);
        apply2(2'b11); chk("sat3", 32'(ec2), 32'd3); chk("sat3.err", 32'(se2), 32'd1);
        apply2(2'b00); chk("sat4", 32'(ec2), 32'd3); chk("sat4.err", 32'(se2), 32'd1);
        apply2(2'b11); chk("sat5", 32'(ec2), 32'd3); chk("sat5.err", 32'(se2), 32'd1);
        apply2(2'b00); chk("sat6", 32'(ec2), 32'd3); chk("sat6.err", 32'(se2), 32'd1);
        chk("sat6.step", 32'(sp2), 32'd0);
        chk("sat.main_hold", 32'(err_cnt), 32'd4);

        // Reset mid-FAULT, checked before the next clock edge
        valid2 = 1'b0;
        rst = 1'b0;
        #2;
        chk_all("midrst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("midrst.sat_errcnt", 32'(ec2), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        apply(1'b1, 2'b10); chk_all("postrst", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
